// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: state encoding, ASCII codes, hex helpers.
package uart_cmd_pkg;

  typedef logic [3:0] state_t;

  // Parse states come first so "accepting rx bytes" is a simple range compare.
  localparam state_t StIdle = 4'd0;
  localparam state_t StAh   = 4'd1;
  localparam state_t StAl   = 4'd2;
  localparam state_t StDh   = 4'd3;
  localparam state_t StDl   = 4'd4;
  localparam state_t StEol  = 4'd5;
  localparam state_t StSkip = 4'd6;
  localparam state_t StExec = 4'd7;
  localparam state_t StWait = 4'd8;
  localparam state_t StResp = 4'd9;

  localparam logic [7:0] AsciiCr   = 8'h0D;
  localparam logic [7:0] AsciiLf   = 8'h0A;
  localparam logic [7:0] AsciiSp   = 8'h20;
  localparam logic [7:0] AsciiW    = 8'h57;
  localparam logic [7:0] AsciiR    = 8'h52;
  localparam logic [7:0] AsciiK    = 8'h4B;
  localparam logic [7:0] AsciiQm   = 8'h3F;
  localparam logic [7:0] AsciiBang = 8'h21;

  // Returns {valid, nibble} for 0-9, a-f, A-F; valid=0 for anything else.
  function automatic logic [4:0] to_nibble(input logic [7:0] c);
    logic [4:0] res;
    res = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      res = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      res = {1'b1, c[3:0] + 4'd9};
    end
    return res;
  endfunction

  // Uppercase ASCII hex digit for a nibble.
  function automatic logic [7:0] to_hex(input logic [3:0] n);
    logic [7:0] res;
    if (n < 4'd10) res = {4'h3, n};
    else           res = 8'h37 + {4'h0, n};
    return res;
  endfunction

endpackage

// File: rtl/uart_cmd_reply.sv
// Reply byte buffer: holds up to four bytes and presents them on a valid/ready stream.
module uart_cmd_reply
  import uart_cmd_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [1:0]      load_last,
  input  logic [3:0][7:0] load_bytes,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            done
);

  logic [3:0][7:0] bytes_q, bytes_d;
  logic [1:0]      idx_q, idx_d;
  logic [1:0]      last_q, last_d;
  logic            valid_q, valid_d;
  logic            xfer;

  // Next-state: a load restarts the buffer; each accepted byte advances the index.
  always_comb begin
    bytes_d = bytes_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    xfer    = valid_q & tx_ready;
    done    = xfer && (idx_q == last_q);
    if (load) begin
      bytes_d = load_bytes;
      idx_d   = 2'd0;
      last_d  = load_last;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (idx_q == last_q) begin
        valid_d = 1'b0;
        idx_d   = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bytes_q <= '0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      bytes_q <= bytes_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Data is forced to zero when idle so the reset/idle value is well defined.
  always_comb begin
    tx_valid = valid_q;
    tx_data  = valid_q ? bytes_q[idx_q] : 8'h00;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII hex command parser: "Waadd<CR>" writes, "Raa<CR>" reads, replies over the tx stream.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rvalid
);

  // Last WAIT count value at which the read is still accepted; 16-bit clamped.
  localparam logic [15:0] TimeoutLast =
      (TIMEOUT > 32'd65535) ? 16'hFFFE :
      (TIMEOUT > 32'd1)     ? 16'(TIMEOUT - 32'd1) : 16'd0;

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            rx_ready_q, rx_ready_d;
  logic            we_q, we_d;
  logic            re_q, re_d;

  logic            rx_fire;
  logic [4:0]      nib;
  logic [7:0]      letter;
  logic            is_sp, is_cr, is_lf;
  logic            load;
  logic [1:0]      load_last;
  logic [3:0][7:0] load_bytes;
  logic            reply_done;

  // Parser FSM next-state, field shifting, bus sequencing and reply loading.
  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    load_last  = 2'd2;
    load_bytes = {8'h00, AsciiLf, AsciiCr, AsciiQm};

    rx_fire = rx_valid & rx_ready_q;
    nib     = to_nibble(rx_data);
    letter  = rx_data & 8'hDF;  // case-fold; only W/w and R/r can map onto 'W'/'R'
    is_sp   = (rx_data == AsciiSp);
    is_cr   = (rx_data == AsciiCr);
    is_lf   = (rx_data == AsciiLf);

    case (state_q)
      StIdle: begin
        if (rx_fire && !is_sp && !is_lf && !is_cr) begin
          if (letter == AsciiW) begin
            is_wr_d = 1'b1;
            state_d = StAh;
          end else if (letter == AsciiR) begin
            is_wr_d = 1'b0;
            state_d = StAh;
          end else begin
            state_d = StSkip;
          end
        end
      end
      StAh, StAl, StDh, StDl: begin
        if (rx_fire && !is_sp) begin
          if (nib[4]) begin
            if (state_q == StAh || state_q == StAl) addr_d  = {addr_q[3:0], nib[3:0]};
            else                                    wdata_d = {wdata_q[3:0], nib[3:0]};
            case (state_q)
              StAh:    state_d = StAl;
              StAl:    state_d = is_wr_q ? StDh : StEol;
              StDh:    state_d = StDl;
              default: state_d = StEol;
            endcase
          end else if (is_cr) begin
            // Truncated line: the CR itself terminates it, so reply at once.
            load    = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StSkip;
          end
        end
      end
      StEol: begin
        if (rx_fire && !is_sp) begin
          state_d = is_cr ? StExec : StSkip;
        end
      end
      StSkip: begin
        if (rx_fire && is_cr) begin
          load    = 1'b1;
          state_d = StResp;
        end
      end
      StExec: begin
        cnt_d = 16'd1;
        if (is_wr_q) begin
          load       = 1'b1;
          load_bytes = {8'h00, AsciiLf, AsciiCr, AsciiK};
          state_d    = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus_rvalid) begin
          load       = 1'b1;
          load_last  = 2'd3;
          load_bytes = {AsciiLf, AsciiCr, to_hex(bus_rdata[3:0]), to_hex(bus_rdata[7:4])};
          state_d    = StResp;
        end else if (cnt_q >= TimeoutLast) begin
          load       = 1'b1;
          load_bytes = {8'h00, AsciiLf, AsciiCr, AsciiBang};
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        if (reply_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Strobes and rx_ready are registered from the next state so they align with it.
    we_d       = (state_d == StExec) && is_wr_d;
    re_d       = (state_d == StExec) && !is_wr_d;
    rx_ready_d = (state_d <= StSkip);
  end

  // Parser state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      is_wr_q    <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      cnt_q      <= 16'd0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      re_q       <= re_d;
    end
  end

  // Output mapping.
  always_comb begin
    rx_ready  = rx_ready_q;
    bus_addr  = addr_q;
    bus_wdata = wdata_q;
    bus_we    = we_q;
    bus_re    = re_q;
  end

  uart_cmd_reply u_reply (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_last  (load_last),
    .load_bytes (load_bytes),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .done       (reply_done)
  );

endmodule
